// File: rtl/dmem_unit.sv
// dmem_unit: byte-lane data memory behind a single-outstanding
// valid/ready request/response channel with fixed latency.
module dmem_unit #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  rd_ctrl,
  input  logic [1:0]  wr_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] wr_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam int IW    = ADDR_W - 2;
  localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nx;
  logic [2:0] cnt;

  logic [3:0][7:0] mem [DEPTH];

  logic          accept;
  logic          err;
  logic          hi_bad;
  logic [IW-1:0] idx;
  logic [1:0]    off;
  logic [3:0]    be;
  logic [31:0]   wdat;
  logic [31:0]   word;
  logic [31:0]   ld_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  assign idx    = req_addr[ADDR_W-1:2];
  assign off    = req_addr[1:0];
  assign hi_bad = |req_addr[31:ADDR_W];
  assign accept = req_valid & req_ready;
  assign word   = mem[idx];

  always_comb begin
    err = hi_bad;
    if (req_we) begin
      case (wr_ctrl)
        2'b01:   err = err | (off != 2'b00);
        2'b10:   err = err | off[0];
        2'b11:   err = err;
        default: err = 1'b1;
      endcase
    end else begin
      case (rd_ctrl)
        3'b001:        err = err | (off != 2'b00);
        3'b010,
        3'b011:        err = err | off[0];
        3'b100,
        3'b101:        err = err;
        default:       err = 1'b1;
      endcase
    end
  end

  // Narrow stores replicate data so lane i always takes wdat[8i+:8]
  always_comb begin
    be   = 4'b0000;
    wdat = wr_data;
    case (wr_ctrl)
      2'b01: be = 4'b1111;
      2'b10: begin
        be   = off[1] ? 4'b1100 : 4'b0011;
        wdat = {2{wr_data[15:0]}};
      end
      2'b11: begin
        be   = 4'b0001 << off;
        wdat = {4{wr_data[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  assign ld_byte = word[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    case (rd_ctrl)
      3'b001:  ld_data = word;
      3'b010:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b011:  ld_data = {16'h0000, ld_half};
      3'b100:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b101:  ld_data = {24'h000000, ld_byte};
      default: ld_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i] <= wdat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = WAIT;
      WAIT:    if (cnt == 3'd0) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 3'd0;
      rsp_data <= 32'h0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      cnt      <= LAT_M1;
      rsp_err  <= err;
      rsp_data <= (err | req_we) ? 32'h0 : ld_data;
    end else if (state == WAIT && cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: two instances (LATENCY 1 and 4) share stimulus and
// are checked against a byte-level memory model.
module tb_dmem_unit;

  localparam int AW = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  rd_ctrl;
  logic [1:0]  wr_ctrl;
  logic [31:0] req_addr;
  logic [31:0] wr_data;
  logic        rsp_ready;

  logic        u1_req_ready, u4_req_ready;
  logic        u1_rsp_valid, u4_rsp_valid;
  logic [31:0] u1_rsp_data, u4_rsp_data;
  logic        u1_rsp_err, u4_rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mm [int];

  typedef struct {
    logic        we;
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t tbl [17];

  always #5 clk = ~clk;

  dmem_unit #(.ADDR_W(AW), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(u1_req_ready),
    .req_we(req_we), .rd_ctrl(rd_ctrl), .wr_ctrl(wr_ctrl),
    .req_addr(req_addr), .wr_data(wr_data),
    .rsp_valid(u1_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(u1_rsp_data), .rsp_err(u1_rsp_err)
  );

  dmem_unit #(.ADDR_W(AW), .LATENCY(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(u4_req_ready),
    .req_we(req_we), .rd_ctrl(rd_ctrl), .wr_ctrl(wr_ctrl),
    .req_addr(req_addr), .wr_data(wr_data),
    .rsp_valid(u4_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(u4_rsp_data), .rsp_err(u4_rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit m_err(logic we, logic [2:0] rd,
                               logic [1:0] wr, logic [31:0] a);
    int sz;
    if (a >= (32'd1 << AW)) return 1'b1;
    if (we) sz = (wr == 1) ? 4 : (wr == 2) ? 2 : (wr == 3) ? 1 : 0;
    else sz = (rd == 1) ? 4 : (rd == 2 || rd == 3) ? 2 :
              (rd == 4 || rd == 5) ? 1 : 0;
    if (sz == 0) return 1'b1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] rd,
                                         logic [31:0] a);
    logic [31:0] w, v;
    int sh;
    w  = mm[int'(a >> 2)];
    sh = 8 * int'(a % 4);
    v  = 32'h0;
    case (rd)
      3'd1: v = w;
      3'd2, 3'd3: begin
        v = (w >> sh) & 32'hFFFF;
        if (rd == 3'd2 && v >= 32'h8000) v = v - 32'h10000;
      end
      3'd4, 3'd5: begin
        v = (w >> sh) & 32'hFF;
        if (rd == 3'd4 && v >= 32'h80) v = v - 32'h100;
      end
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic void m_store(logic [1:0] wr, logic [31:0] a,
                                  logic [31:0] wd);
    logic [31:0] mask, w;
    int k, sh;
    k  = int'(a >> 2);
    sh = 8 * int'(a % 4);
    w  = mm.exists(k) ? mm[k] : 32'hxxxxxxxx;
    case (wr)
      2'd1:    mask = 32'hFFFFFFFF;
      2'd2:    mask = 32'hFFFF << sh;
      default: mask = 32'hFF << sh;
    endcase
    mm[k] = (w & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic xact(input logic we, input logic [2:0] rd,
                      input logic [1:0] wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] ed,
                      input logic ee, input int stall,
                      input string nm);
    int t, l1, l4;
    logic [31:0] h1d, h4d;
    logic h1e, h4e;
    bit ok;
    @(negedge clk);
    chk({nm, "/ready"}, {31'd0, u1_req_ready & u4_req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    rd_ctrl   = rd;
    wr_ctrl   = wr;
    req_addr  = a;
    wr_data   = wd;
    @(posedge clk); #1;
    // stray store offered while busy; must be ignored
    req_we   = 1'b1;
    wr_ctrl  = 2'b01;
    rd_ctrl  = 3'b001;
    req_addr = 32'($urandom_range(0, 63)) * 4;
    wr_data  = $urandom;
    l1 = -1; l4 = -1; t = 0; ok = 1'b1;
    h1d = 'x; h4d = 'x; h1e = 'x; h4e = 'x;
    while (l4 < 0 && t < 16) begin
      if (u1_req_ready || u4_req_ready) ok = 1'b0;
      if (l1 >= 0 && (!u1_rsp_valid || u1_rsp_data !== h1d ||
                      u1_rsp_err !== h1e)) ok = 1'b0;
      @(posedge clk); #1;
      t++;
      if (l1 < 0 && u1_rsp_valid) begin
        l1 = t; h1d = u1_rsp_data; h1e = u1_rsp_err;
      end
      if (u4_rsp_valid) begin
        l4 = t; h4d = u4_rsp_data; h4e = u4_rsp_err;
      end
    end
    repeat (stall) begin
      @(posedge clk); #1;
      if (u1_req_ready || u4_req_ready) ok = 1'b0;
      if (!u1_rsp_valid || u1_rsp_data !== h1d ||
          u1_rsp_err !== h1e) ok = 1'b0;
      if (!u4_rsp_valid || u4_rsp_data !== h4d ||
          u4_rsp_err !== h4e) ok = 1'b0;
    end
    chk({nm, "/lat1"}, 32'(l1), 32'd1);
    chk({nm, "/lat4"}, 32'(l4), 32'd4);
    chk({nm, "/data1"}, h1d, ed);
    chk({nm, "/err1"}, {31'd0, h1e}, {31'd0, ee});
    chk({nm, "/data4"}, h4d, ed);
    chk({nm, "/err4"}, {31'd0, h4e}, {31'd0, ee});
    chk({nm, "/stable"}, {31'd0, ok}, 32'd1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({nm, "/ready_after"},
        {30'd0, u1_req_ready, u4_req_ready}, 32'd3);
    chk({nm, "/valid_after"},
        {30'd0, u1_rsp_valid, u4_rsp_valid}, 32'd0);
  endtask

  initial begin
    logic        we, e;
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] a, wd, d;

    tbl[0]  = '{1'b1, 3'd0, 2'd1, 32'h10,   32'hDEADBEEF, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 3'd1, 2'd0, 32'h10,   32'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 3'd4, 2'd0, 32'h13,   32'h0, 32'hFFFFFFDE, 1'b0};
    tbl[3]  = '{1'b0, 3'd5, 2'd0, 32'h13,   32'h0, 32'h000000DE, 1'b0};
    tbl[4]  = '{1'b0, 3'd2, 2'd0, 32'h10,   32'h0, 32'hFFFFBEEF, 1'b0};
    tbl[5]  = '{1'b0, 3'd3, 2'd0, 32'h12,   32'h0, 32'h0000DEAD, 1'b0};
    tbl[6]  = '{1'b1, 3'd0, 2'd3, 32'h11,   32'h5A,   32'h0, 1'b0};
    tbl[7]  = '{1'b0, 3'd1, 2'd0, 32'h10,   32'h0, 32'hDEAD5AEF, 1'b0};
    tbl[8]  = '{1'b1, 3'd0, 2'd2, 32'h12,   32'h1234, 32'h0, 1'b0};
    tbl[9]  = '{1'b0, 3'd1, 2'd0, 32'h10,   32'h0, 32'h12345AEF, 1'b0};
    tbl[10] = '{1'b0, 3'd1, 2'd0, 32'h12,   32'h0,    32'h0, 1'b1};
    tbl[11] = '{1'b1, 3'd0, 2'd2, 32'h11,   32'hFFFF, 32'h0, 1'b1};
    tbl[12] = '{1'b0, 3'd1, 2'd0, 32'h1000, 32'h0,    32'h0, 1'b1};
    tbl[13] = '{1'b1, 3'd0, 2'd1, 32'h1010, 32'h0,    32'h0, 1'b1};
    tbl[14] = '{1'b0, 3'd7, 2'd0, 32'h10,   32'h0,    32'h0, 1'b1};
    tbl[15] = '{1'b1, 3'd0, 2'd0, 32'h10,   32'h0,    32'h0, 1'b1};
    tbl[16] = '{1'b0, 3'd1, 2'd0, 32'h10,   32'h0, 32'h12345AEF, 1'b0};

    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    rd_ctrl   = 3'd0;
    wr_ctrl   = 2'd0;
    req_addr  = 32'h0;
    wr_data   = 32'h0;
    rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst/ready", {30'd0, u1_req_ready, u4_req_ready}, 32'd3);
    chk("rst/valid", {30'd0, u1_rsp_valid, u4_rsp_valid}, 32'd0);
    chk("rst/err", {30'd0, u1_rsp_err, u4_rsp_err}, 32'd0);
    chk("rst/data1", u1_rsp_data, 32'h0);
    chk("rst/data4", u4_rsp_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      xact(tbl[i].we, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd,
           tbl[i].ed, tbl[i].ee, i % 4, $sformatf("vec%0d", i));
      if (tbl[i].we && !tbl[i].ee) m_store(tbl[i].wr, tbl[i].a, tbl[i].wd);
    end

    // reset while both units hold a committed store in WAIT
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    wr_ctrl   = 2'b01;
    req_addr  = 32'h20;
    wr_data   = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst/ready", {30'd0, u1_req_ready, u4_req_ready}, 32'd3);
    chk("midrst/valid", {30'd0, u1_rsp_valid, u4_rsp_valid}, 32'd0);
    chk("midrst/data4", u4_rsp_data, 32'h0);
    #1 rst_n = 1'b1;
    m_store(2'd1, 32'h20, 32'hCAFEF00D);
    xact(1'b0, 3'd1, 2'd0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1,
         "midrst/lw");

    for (int i = 0; i < 64; i++) begin
      wd = $urandom;
      xact(1'b1, 3'd0, 2'd1, 32'(i * 4), wd, 32'h0, 1'b0, 0,
           $sformatf("init%0d", i));
      m_store(2'd1, 32'(i * 4), wd);
    end

    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      rd = 3'($urandom_range(0, 7));
      wr = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0)
        a = a | (32'h1 << $urandom_range(AW, 31));
      wd = $urandom;
      e  = m_err(we, rd, wr, a);
      d  = (we || e) ? 32'h0 : m_load(rd, a);
      xact(we, rd, wr, a, wd, d, e, $urandom_range(0, 3),
           $sformatf("rnd%0d", i));
      if (we && !e) m_store(wr, a, wd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_unit.md
DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: byte-address bits decoded, giving 2^(ADDR_W-2) 32-bit words; legal range 4..20.
REQ-002 SHALL have parameter LATENCY, default 1: cycles from request acceptance to response; legal range 1..8.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1: request present.
REQ-006 SHALL have port req_ready  output  1: unit can accept a request.
REQ-007 SHALL have port req_we  input  1: 1 = store, 0 = load.
REQ-008 SHALL have port rd_ctrl  input  3: load type; 001 lw, 010 lh, 011 lhu, 100 lb, 101 lbu; others illegal.
REQ-009 SHALL have port wr_ctrl  input  2: store type; 01 sw, 10 sh, 11 sb; 00 illegal.
REQ-010 SHALL have port req_addr  input  32: byte address.
REQ-011 SHALL have port wr_data  input  32: store data, right-aligned: byte in [7:0], half in [15:0].
REQ-012 SHALL have port rsp_valid  output  1: response present.
REQ-013 SHALL have port rsp_ready  input  1: consumer accepts response.
REQ-014 SHALL have port rsp_data  output  32: load result; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1: request faulted.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE, one outstanding request.
REQ-017 SHALL drive req_ready = 1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge with req_valid && req_ready, then enter WAIT with a latency counter loaded to LATENCY-1.
REQ-019 SHALL, in WAIT, decrement the counter each edge and move to RESP on the edge where the counter is 0; LATENCY=1 therefore gives rsp_valid high in the cycle after the accept edge, and LATENCY=N gives it N cycles after.
REQ-020 SHALL hold rsp_valid, rsp_data and rsp_err stable in RESP until an edge with rsp_ready = 1, then return to IDLE; req_ready rises in the following cycle.
REQ-021 SHALL flag an error when any of these hold: req_addr[31:ADDR_W] != 0; lw/sw with addr[1:0] != 0; lh/lhu/sh with addr[0] != 0; illegal rd_ctrl or wr_ctrl encoding.
REQ-022 SHALL, for an error, perform no memory write and return rsp_err = 1, rsp_data = 0 after the same LATENCY.
REQ-023 SHALL commit a legal store to memory on the accept edge, using byte-lane write enables: sb writes lane addr[1:0], sh writes lanes addr[1]*2 and addr[1]*2+1, sw writes all four lanes. Other lanes SHALL be unchanged.
REQ-024 SHALL return rsp_err = 0 and rsp_data = 0 for a legal store.
REQ-025 SHALL sample the addressed word for a load on the accept edge, so a load sees all earlier stores.
REQ-026 SHALL form load data as follows: lb/lbu select byte addr[1:0]; lh/lhu select half addr[1]; lb/lh sign-extend to 32 bits; lbu/lhu zero-extend.
REQ-027 SHALL ignore req_* while not in IDLE.
REQ-028 SHALL leave memory contents uninitialised; a read of a never-written word is X in simulation.

Reset
REQ-029 SHALL, on rst_n = 0, immediately force state IDLE, counter 0, rsp_valid 0, rsp_data 0, rsp_err 0 and req_ready 1, regardless of clk.
REQ-030 SHALL, on reset during WAIT or RESP, discard the pending response; a store already committed on its accept edge SHALL remain in memory.
REQ-031 SHALL not clear memory contents on reset.

Verification
REQ-032 SHALL cover: LATENCY=1, sw 0xDEADBEEF to 0x10, then lw 0x10 -> rsp_valid exactly 1 cycle after each accept edge, load rsp_data = 0xDEADBEEF, rsp_err = 0.
REQ-033 SHALL cover: word 0x10 = 0xDEADBEEF; lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x10 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000DEAD.
REQ-034 SHALL cover: sb 0x5A to 0x11 over word 0xDEADBEEF -> later lw 0x10 returns 0xDEAD5AEF; sh 0x1234 to 0x12 -> lw 0x10 returns 0x12345AEF.
REQ-035 SHALL cover: lw 0x12, sh 0x11, and lw 0x1000 (ADDR_W=12) -> rsp_err = 1, rsp_data = 0, memory unchanged.
REQ-036 SHALL cover: LATENCY=4, rsp_ready held 0 for 3 cycles -> rsp_valid high 4 cycles after accept, outputs stable while stalled, req_ready low until 1 cycle after the rsp handshake.
REQ-037 SHALL cover: rst_n pulsed low mid-WAIT after a sw 0xCAFEF00D to 0x20 -> rsp_valid 0 and req_ready 1 asynchronously; a subsequent lw 0x20 returns 0xCAFEF00D.
